// File: rtl/plab3_mem_line_to_word_adapter.sv
// Splits each cache-line memory request into four word requests to a word-wide
// memory, one in flight at a time, and reassembles read words into a line response.
module plab3_mem_line_to_word_adapter #(
  parameter int p_opaque_nbits = 8,
  parameter int abw            = 32,
  parameter int clw            = 128,
  parameter int dbw            = 32,
  localparam int CLEN    = $clog2(clw/8),
  localparam int DLEN    = $clog2(dbw/8),
  localparam int LREQ_W  = 3 + p_opaque_nbits + abw + CLEN + clw,
  localparam int LRESP_W = 3 + p_opaque_nbits + CLEN + clw,
  localparam int WREQ_W  = 3 + p_opaque_nbits + abw + DLEN + dbw,
  localparam int WRESP_W = 3 + p_opaque_nbits + DLEN + dbw
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               domain,
  input  logic               linereq_val,
  output logic               linereq_rdy,
  input  logic [LREQ_W-1:0]  linereq_msg,
  output logic               lineresp_val,
  input  logic               lineresp_rdy,
  output logic [LRESP_W-1:0] lineresp_msg,
  output logic               wordreq_val,
  input  logic               wordreq_rdy,
  output logic [WREQ_W-1:0]  wordreq_msg,
  output logic               wordreq_domain,
  input  logic               wordresp_val,
  output logic               wordresp_rdy,
  input  logic [WRESP_W-1:0] wordresp_msg,
  output logic               protocol_err
);

  localparam int O  = p_opaque_nbits;
  localparam int NW = clw / dbw;
  localparam int IW = $clog2(NW);
  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      type_q, type_d;
  logic [O-1:0]    opaque_q, opaque_d;
  logic [abw-1:0]  base_q, base_d;
  logic [clw-1:0]  data_q, data_d;
  logic [clw-1:0]  line_buf_q, line_buf_d;
  logic            domain_q, domain_d;
  logic            err_q, err_d;

  logic [2:0]      lreq_type;
  logic [O-1:0]    lreq_opaque;
  logic [abw-1:0]  lreq_addr;
  logic [CLEN-1:0] lreq_len;
  logic [clw-1:0]  lreq_data;
  logic [2:0]      wresp_type;
  logic [O-1:0]    wresp_opaque;
  logic [DLEN-1:0] wresp_len;
  logic [dbw-1:0]  wresp_data;

  assign {lreq_type, lreq_opaque, lreq_addr, lreq_len, lreq_data} = linereq_msg;
  assign {wresp_type, wresp_opaque, wresp_len, wresp_data}        = wordresp_msg;

  // Length fields and the opaque bits above the word index carry nothing we use.
  logic unused_bits;
  assign unused_bits = ^{lreq_len, wresp_len, wresp_opaque[O-1:IW]};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    type_d       = type_q;
    opaque_d     = opaque_q;
    base_d       = base_q;
    data_d       = data_q;
    line_buf_d   = line_buf_q;
    domain_d     = domain_q;
    err_d        = err_q;
    linereq_rdy  = 1'b0;
    wordreq_val  = 1'b0;
    wordresp_rdy = 1'b0;
    lineresp_val = 1'b0;
    case (state_q)
      S_IDLE: begin
        linereq_rdy = 1'b1;
        if (linereq_val) begin
          // Unknown line types are flagged and then serviced as reads.
          type_d   = (lreq_type == TYPE_WRITE) ? TYPE_WRITE : TYPE_READ;
          err_d    = err_q | (lreq_type > TYPE_WRITE);
          opaque_d = lreq_opaque;
          base_d   = {lreq_addr[abw-1:CLEN], {CLEN{1'b0}}};
          data_d   = lreq_data;
          domain_d = domain;
          idx_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        wordreq_val = 1'b1;
        if (wordreq_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        wordresp_rdy = 1'b1;
        if (wordresp_val) begin
          if (type_q == TYPE_READ) line_buf_d[idx_q*dbw +: dbw] = wresp_data;
          if (wresp_opaque[IW-1:0] != idx_q || wresp_type != type_q) err_d = 1'b1;
          if (idx_q == IW'(NW-1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        lineresp_val = 1'b1;
        if (lineresp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs derive only from registered state, so they hold under backpressure.
  assign wordreq_msg = {type_q, O'(idx_q),
                        base_q + (abw'(idx_q) << $clog2(dbw/8)),
                        {DLEN{1'b0}},
                        (type_q == TYPE_WRITE) ? data_q[idx_q*dbw +: dbw] : {dbw{1'b0}}};
  assign wordreq_domain = domain_q;
  assign lineresp_msg   = {type_q, opaque_q, {CLEN{1'b0}},
                           (type_q == TYPE_READ) ? line_buf_q : {clw{1'b0}}};
  assign protocol_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      type_q     <= '0;
      opaque_q   <= '0;
      base_q     <= '0;
      data_q     <= '0;
      line_buf_q <= '0;
      domain_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      type_q     <= type_d;
      opaque_q   <= opaque_d;
      base_q     <= base_d;
      data_q     <= data_d;
      line_buf_q <= line_buf_d;
      domain_q   <= domain_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_plab3_mem_line_to_word_adapter.sv
// Randomized bench for the line-to-word adapter: a transaction-level model predicts
// every output each cycle; directed cases pin the model with literal values.
module tb_plab3_mem_line_to_word_adapter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic domain = 1'b0;
  logic linereq_val = 1'b0;
  logic linereq_rdy;
  logic [174:0] linereq_msg = '0;
  logic lineresp_val;
  logic lineresp_rdy = 1'b1;
  logic [142:0] lineresp_msg;
  logic wordreq_val;
  logic wordreq_rdy = 1'b1;
  logic [76:0] wordreq_msg;
  logic wordreq_domain;
  logic wordresp_val = 1'b0;
  logic wordresp_rdy;
  logic [44:0] wordresp_msg = '0;
  logic protocol_err;

  plab3_mem_line_to_word_adapter dut (
    .clk(clk), .reset(reset), .domain(domain),
    .linereq_val(linereq_val), .linereq_rdy(linereq_rdy), .linereq_msg(linereq_msg),
    .lineresp_val(lineresp_val), .lineresp_rdy(lineresp_rdy), .lineresp_msg(lineresp_msg),
    .wordreq_val(wordreq_val), .wordreq_rdy(wordreq_rdy), .wordreq_msg(wordreq_msg),
    .wordreq_domain(wordreq_domain),
    .wordresp_val(wordresp_val), .wordresp_rdy(wordresp_rdy), .wordresp_msg(wordresp_msg),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Transaction-level model state
  bit           busy = 0;
  int           ic = 0, rc = 0;      // words issued / words answered
  bit           m_err = 0;
  logic [2:0]   teff;
  logic [7:0]   mop;
  logic [31:0]  mbase;
  logic [127:0] mdata, mrd;
  logic         mdom;
  int           cyc = 0, acc_cyc = 0, last_lat = 0, lines_done = 0;
  bit           lat_seen = 0;
  logic [31:0]  mem [logic [31:0]];
  logic [44:0]  pend [$];
  logic [31:0]  wl_addr [$];
  logic [31:0]  wl_data [$];
  logic [7:0]   wl_op [$];
  logic         wl_dom [$];
  logic [127:0] last_ldata;
  logic [2:0]   last_ltype;
  logic [7:0]   last_lop;
  bit           prev_w = 0, prev_l = 0;
  logic [77:0]  prev_wm;
  logic [142:0] prev_lm;

  // Environment controls
  bit stall = 0;
  int resp_limit = 4;
  int lresp_hold = 0;
  bit bad_op_next = 0;

  task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [76:0] exp_wreq(input int k);
    logic [31:0] w;
    w = (teff == 3'd1) ? mdata[32*k +: 32] : 32'h0;
    return {teff, 8'(k), mbase + 32'(4*k), 2'b00, w};
  endfunction

  // Compare process: check every output against the model, then advance the model
  always @(negedge clk) begin
    bit exp_wv, exp_wr, exp_lv;
    logic [2:0]  t;
    logic [31:0] a, dw;
    logic [44:0] r;
    cyc++;
    if (reset) begin
      busy = 0; ic = 0; rc = 0; m_err = 0; prev_w = 0; prev_l = 0;
      pend.delete();
    end else begin
      exp_wv = busy && ic == rc && rc < 4;
      exp_wr = busy && ic == rc + 1;
      exp_lv = busy && rc == 4;
      chk("linereq_rdy", 176'(linereq_rdy), 176'(!busy));
      chk("wordreq_val", 176'(wordreq_val), 176'(exp_wv));
      if (exp_wv) begin
        chk("wordreq_msg", 176'(wordreq_msg), 176'(exp_wreq(rc)));
        chk("wordreq_domain", 176'(wordreq_domain), 176'(mdom));
      end
      if (prev_w) chk("wordreq_hold", 176'({wordreq_domain, wordreq_msg}), 176'(prev_wm));
      chk("wordresp_rdy", 176'(wordresp_rdy), 176'(exp_wr));
      chk("lineresp_val", 176'(lineresp_val), 176'(exp_lv));
      if (exp_lv) begin
        chk("lineresp_msg", 176'(lineresp_msg),
            176'({teff, mop, 4'h0, (teff == 3'd0) ? mrd : 128'h0}));
        if (!lat_seen) begin lat_seen = 1; last_lat = cyc - acc_cyc; end
      end
      if (prev_l) chk("lineresp_hold", 176'(lineresp_msg), 176'(prev_lm));
      chk("protocol_err", 176'(protocol_err), 176'(m_err));
      prev_w = exp_wv && !wordreq_rdy;
      prev_wm = {wordreq_domain, wordreq_msg};
      prev_l = exp_lv && !lineresp_rdy;
      prev_lm = lineresp_msg;

      if (linereq_val && !busy) begin
        t = linereq_msg[174:172];
        teff = (t == 3'd1) ? 3'd1 : 3'd0;
        if (t > 3'd1) m_err = 1;
        mop = linereq_msg[171:164];
        mbase = {linereq_msg[163:136], 4'h0};
        mdata = linereq_msg[127:0];
        mdom = domain;
        mrd = {mem_rd(mbase + 32'd12), mem_rd(mbase + 32'd8), mem_rd(mbase + 32'd4), mem_rd(mbase)};
        busy = 1; ic = 0; rc = 0; acc_cyc = cyc; lat_seen = 0;
      end
      if (exp_wv && wordreq_rdy) begin
        a = mbase + 32'(4*ic);
        dw = mdata[32*ic +: 32];
        if (teff == 3'd1) mem[a] = dw;
        r = {teff, 8'(ic), 2'b00, (teff == 3'd0) ? mem_rd(a) : 32'h0};
        if (bad_op_next && ic == 1) begin r[41:34] = 8'd2; bad_op_next = 0; end
        pend.push_back(r);
        wl_addr.push_back(wordreq_msg[65:34]);
        wl_data.push_back(wordreq_msg[31:0]);
        wl_op.push_back(wordreq_msg[73:66]);
        wl_dom.push_back(wordreq_domain);
        ic++;
      end
      if (wordresp_val && exp_wr && pend.size() > 0) begin
        r = pend.pop_front();
        if (r[35:34] != 2'(rc) || r[44:42] != teff) m_err = 1;
        rc++;
      end
      if (exp_lv && lineresp_rdy) begin
        busy = 0;
        last_ldata = lineresp_msg[127:0];
        last_ltype = lineresp_msg[142:140];
        last_lop = lineresp_msg[139:132];
        lines_done++;
      end
    end
  end

  // Memory side and line-response consumer
  always @(posedge clk) begin
    #1;
    wordreq_rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!reset && pend.size() > 0 && rc < resp_limit && (!stall || $urandom_range(0, 2) != 0)) begin
      wordresp_val = 1'b1;
      wordresp_msg = pend[0];
    end else begin
      wordresp_val = 1'b0;
      wordresp_msg = 45'($urandom);
    end
    if (lineresp_val && lresp_hold > 0) begin
      lineresp_rdy = 1'b0;
      lresp_hold--;
    end else begin
      lineresp_rdy = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  end

  task automatic send_line(input logic [2:0] t, input logic [31:0] a, input logic [127:0] d,
                           input logic [7:0] op, input logic dm);
    int n = 0;
    linereq_val = 1'b1;
    linereq_msg = {t, op, a, 4'h0, d};
    domain = dm;
    @(negedge clk);
    while (!linereq_rdy && n < 3000) begin @(negedge clk); n++; end
    if (!linereq_rdy) begin
      n_chk++; n_err++;
      $display("FAIL send_line timeout: linereq_rdy got 0 expected 1");
    end
    @(posedge clk); #1;
    linereq_val = 1'b0;
    domain = $urandom_range(0, 1);
    linereq_msg = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (busy) begin
      n_chk++; n_err++;
      $display("FAIL wait_idle timeout: busy got 1 expected 0");
    end
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] LINE_A = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] LINE_W = 128'h44444444_33333333_22222222_11111111;

  initial begin
    logic [31:0] wexp [4];
    int n, ld;
    wexp = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    mem[32'h1000] = 32'hA0A0A0A0; mem[32'h1004] = 32'hA1A1A1A1;
    mem[32'h1008] = 32'hA2A2A2A2; mem[32'h100C] = 32'hA3A3A3A3;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_linereq_rdy", 176'(linereq_rdy), 176'(1'b1));
    chk("rst_lineresp_val", 176'(lineresp_val), 176'(1'b0));
    chk("rst_wordreq_val", 176'(wordreq_val), 176'(1'b0));
    chk("rst_wordresp_rdy", 176'(wordresp_rdy), 176'(1'b0));
    chk("rst_protocol_err", 176'(protocol_err), 176'(1'b0));
    @(posedge clk); #1;

    // 1: read line, unaligned address, zero-wait memory
    wl_addr.delete(); wl_op.delete();
    send_line(3'd0, 32'h00001004, 128'h0, 8'h5A, 1'b0);
    wait_idle();
    chk("t1_nwords", 176'(wl_addr.size()), 176'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 176'(wl_addr[i]), 176'(32'h1000 + 32'(4*i)));
      chk("t1_opaque", 176'(wl_op[i]), 176'(i));
    end
    chk("t1_data", 176'(last_ldata), 176'(LINE_A));
    chk("t1_type", 176'(last_ltype), 176'(3'd0));
    chk("t1_opaque_echo", 176'(last_lop), 176'(8'h5A));
    chk("t1_latency", 176'(last_lat), 176'(9));

    // 2: write line
    wl_addr.delete(); wl_data.delete();
    send_line(3'd1, 32'h00002000, LINE_W, 8'h11, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", 176'(wl_addr[i]), 176'(32'h2000 + 32'(4*i)));
      chk("t2_wdata", 176'(wl_data[i]), 176'(wexp[i]));
    end
    chk("t2_type", 176'(last_ltype), 176'(3'd1));
    chk("t2_data", 176'(last_ldata), 176'(128'h0));

    // 3: random stalls plus held line response
    stall = 1; lresp_hold = 5;
    send_line(3'd0, 32'h00001008, 128'h0, 8'h22, 1'b0);
    wait_idle();
    stall = 0; lresp_hold = 0;
    chk("t3_data", 176'(last_ldata), 176'(LINE_A));

    // 5: out-of-order opaque on word 1 is sticky across later good lines
    bad_op_next = 1;
    send_line(3'd0, 32'h00001000, 128'h0, 8'h33, 1'b0);
    wait_idle();
    chk("t5_err", 176'(protocol_err), 176'(1'b1));
    chk("t5_data", 176'(last_ldata), 176'(LINE_A));
    send_line(3'd0, 32'h00001000, 128'h0, 8'h34, 1'b0);
    wait_idle();
    chk("t5_err_sticky", 176'(protocol_err), 176'(1'b1));

    // 4: reset while waiting on word 1
    resp_limit = 1;
    ld = lines_done;
    send_line(3'd0, 32'h00002000, 128'h0, 8'h44, 1'b0);
    n = 0;
    while (ic < 2 && n < 200) begin @(negedge clk); n++; end
    chk("t4_reached_wait", 176'(ic), 176'(2));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    resp_limit = 4;
    @(negedge clk);
    chk("t4_linereq_rdy", 176'(linereq_rdy), 176'(1'b1));
    chk("t4_lineresp_val", 176'(lineresp_val), 176'(1'b0));
    chk("t4_err_cleared", 176'(protocol_err), 176'(1'b0));
    repeat (5) @(negedge clk);
    chk("t4_no_resp", 176'(lines_done), 176'(ld));
    @(posedge clk); #1;
    send_line(3'd0, 32'h00002000, 128'h0, 8'h45, 1'b0);
    wait_idle();
    chk("t4_after_data", 176'(last_ldata), 176'(LINE_W));

    // Unknown line type proceeds as a read and flags an error
    send_line(3'd3, 32'h00001000, 128'hDEAD, 8'h55, 1'b0);
    wait_idle();
    chk("badtype_err", 176'(protocol_err), 176'(1'b1));
    chk("badtype_type", 176'(last_ltype), 176'(3'd0));
    chk("badtype_data", 176'(last_ldata), 176'(LINE_A));

    // 6: back-to-back lines from different domains
    wl_dom.delete();
    send_line(3'd0, 32'h00001000, 128'h0, 8'h61, 1'b1);
    send_line(3'd0, 32'h00002000, 128'h0, 8'h62, 1'b0);
    wait_idle();
    chk("t6_nwords", 176'(wl_dom.size()), 176'(8));
    for (int i = 0; i < 8 && i < wl_dom.size(); i++)
      chk("t6_domain", 176'(wl_dom[i]), 176'(i < 4 ? 1'b1 : 1'b0));

    // Random lines under random backpressure
    stall = 1;
    for (int i = 0; i < 25; i++)
      send_line($urandom_range(0, 1) == 0 ? 3'd0 : 3'd1,
                32'h3000 + 32'($urandom_range(0, 15) * 16) + 32'($urandom_range(0, 15)),
                {$urandom, $urandom, $urandom, $urandom}, 8'($urandom), 1'($urandom));
    wait_idle();
    stall = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
